// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared state encodings, write-port owner type and width defaults for the RSA job path
package rsa_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;
  localparam logic [1:0] ST_SEND    = 2'd3;

  localparam int ABITS_DEF = 8;
  localparam int DBITS_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LD   = 2'd1,
    OWN_MX   = 2'd2
  } wr_owner_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bram_wr_mux.sv
// rtl/bram_wr_mux.sv - single BRAM write port shared by loader and mon_exp, flags writes from the non-owner
module bram_wr_mux
  import rsa_pkg::*;
#(
  parameter int ABITS = ABITS_DEF,
  parameter int DBITS = DBITS_DEF
) (
  input  wr_owner_t          owner,
  input  logic [ABITS-1:0]   ld_wr_addr,
  input  logic [DBITS-1:0]   ld_wr_data,
  input  logic               ld_wr_en,
  input  logic [ABITS-1:0]   mx_wr_addr,
  input  logic [DBITS-1:0]   mx_wr_data,
  input  logic               mx_wr_en,
  output logic [ABITS-1:0]   br_wr_addr,
  output logic [DBITS-1:0]   br_wr_data,
  output logic               br_wr_en,
  output logic               conflict
);

  always_comb begin
    br_wr_addr = '0;
    br_wr_data = '0;
    br_wr_en   = 1'b0;
    conflict   = 1'b0;
    case (owner)
      OWN_LD: begin
        br_wr_addr = ld_wr_addr;
        br_wr_data = ld_wr_data;
        br_wr_en   = ld_wr_en;
        conflict   = mx_wr_en;
      end
      OWN_MX: begin
        br_wr_addr = mx_wr_addr;
        br_wr_data = mx_wr_data;
        br_wr_en   = mx_wr_en;
        conflict   = ld_wr_en;
      end
      // with no owner, any request is a stray write
      default: conflict = ld_wr_en | mx_wr_en;
    endcase
  end

endmodule

// File: rtl/rsa_session_ctrl.sv
// rtl/rsa_session_ctrl.sv - LOAD -> COMPUTE -> SEND sequencer for one RSA job, with rx gating and BRAM write ownership
module rsa_session_ctrl
  import rsa_pkg::*;
#(
  parameter int ABITS        = ABITS_DEF,
  parameter int DBITS        = DBITS_DEF,
  parameter int TO_W         = 24,
  parameter int LOAD_TIMEOUT = 12000000,
  parameter int QUIET_W      = 12,
  parameter int SEND_QUIET   = 2500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_byte,
  input  logic               rx_error,
  output logic               ld_rx_valid,
  output logic [7:0]         ld_rx_byte,
  output logic               ld_flush,
  input  logic               ld_done,
  input  logic [ABITS-1:0]   ld_wr_addr,
  input  logic [DBITS-1:0]   ld_wr_data,
  input  logic               ld_wr_en,
  output logic               mx_start,
  input  logic               mx_stop,
  input  logic [ABITS-1:0]   mx_wr_addr,
  input  logic [DBITS-1:0]   mx_wr_data,
  input  logic               mx_wr_en,
  output logic [ABITS-1:0]   br_wr_addr,
  output logic [DBITS-1:0]   br_wr_data,
  output logic               br_wr_en,
  output logic               ps_start,
  input  logic               tx_busy,
  output logic [1:0]         state,
  output logic [7:0]         drop_cnt,
  output logic               wr_conflict
);

  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(LOAD_TIMEOUT - 1);
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(SEND_QUIET - 1);

  logic [TO_W-1:0]    to_cnt;
  logic [QUIET_W-1:0] quiet_cnt;
  logic               seen_tx;
  logic               accept_rx;
  logic               conflict;
  wr_owner_t          owner;

  assign accept_rx   = (state == ST_IDLE) || (state == ST_LOAD);
  assign ld_rx_valid = rx_valid & accept_rx;
  assign ld_rx_byte  = rx_byte;

  always_comb begin
    case (state)
      ST_LOAD:    owner = OWN_LD;
      ST_COMPUTE: owner = OWN_MX;
      default:    owner = OWN_NONE;
    endcase
  end

  bram_wr_mux #(
    .ABITS(ABITS),
    .DBITS(DBITS)
  ) u_wr_mux (
    .owner      (owner),
    .ld_wr_addr (ld_wr_addr),
    .ld_wr_data (ld_wr_data),
    .ld_wr_en   (ld_wr_en),
    .mx_wr_addr (mx_wr_addr),
    .mx_wr_data (mx_wr_data),
    .mx_wr_en   (mx_wr_en),
    .br_wr_addr (br_wr_addr),
    .br_wr_data (br_wr_data),
    .br_wr_en   (br_wr_en),
    .conflict   (conflict)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      to_cnt      <= '0;
      quiet_cnt   <= '0;
      seen_tx     <= 1'b0;
      mx_start    <= 1'b0;
      ps_start    <= 1'b0;
      ld_flush    <= 1'b0;
      drop_cnt    <= 8'd0;
      wr_conflict <= 1'b0;
    end else begin
      mx_start <= 1'b0;
      ps_start <= 1'b0;
      ld_flush <= 1'b0;

      if (rx_valid && !accept_rx) drop_cnt <= sat_inc8(drop_cnt);
      if (conflict) wr_conflict <= 1'b1;

      case (state)
        ST_IDLE: begin
          to_cnt <= '0;
          if (rx_valid) state <= ST_LOAD;
        end
        ST_LOAD: begin
          // a completed load outranks a simultaneous abort
          if (ld_done) begin
            state    <= ST_COMPUTE;
            mx_start <= 1'b1;
            to_cnt   <= '0;
          end else if (rx_error || to_cnt == TO_LAST) begin
            state    <= ST_IDLE;
            ld_flush <= 1'b1;
            to_cnt   <= '0;
          end else if (rx_valid) begin
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_COMPUTE: begin
          if (mx_stop) begin
            state     <= ST_SEND;
            ps_start  <= 1'b1;
            seen_tx   <= 1'b0;
            quiet_cnt <= '0;
          end
        end
        ST_SEND: begin
          // quiet time only counts once the transmitter has actually started
          if (tx_busy) begin
            seen_tx   <= 1'b1;
            quiet_cnt <= '0;
          end else if (seen_tx) begin
            if (quiet_cnt == QUIET_LAST) begin
              state     <= ST_IDLE;
              seen_tx   <= 1'b0;
              quiet_cnt <= '0;
            end else begin
              quiet_cnt <= quiet_cnt + QUIET_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_session_ctrl.sv
// tb/tb_rsa_session_ctrl.sv - randomized and directed bench for rsa_session_ctrl against a phase-level model
module tb_rsa_session_ctrl;

  localparam int LT = 1000;
  localparam int SQ = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid, rx_error, ld_done, ld_wr_en, mx_stop, mx_wr_en, tx_busy;
  logic [7:0]  rx_byte, ld_wr_addr, mx_wr_addr;
  logic [31:0] ld_wr_data, mx_wr_data;
  logic        ld_rx_valid, ld_flush, mx_start, ps_start, br_wr_en, wr_conflict;
  logic [7:0]  ld_rx_byte, br_wr_addr, drop_cnt;
  logic [31:0] br_wr_data;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  rsa_session_ctrl #(
    .ABITS(8), .DBITS(32), .TO_W(24), .LOAD_TIMEOUT(LT), .QUIET_W(12), .SEND_QUIET(SQ)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
    .ld_rx_valid(ld_rx_valid), .ld_rx_byte(ld_rx_byte), .ld_flush(ld_flush),
    .ld_done(ld_done), .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data), .ld_wr_en(ld_wr_en),
    .mx_start(mx_start), .mx_stop(mx_stop),
    .mx_wr_addr(mx_wr_addr), .mx_wr_data(mx_wr_data), .mx_wr_en(mx_wr_en),
    .br_wr_addr(br_wr_addr), .br_wr_data(br_wr_data), .br_wr_en(br_wr_en),
    .ps_start(ps_start), .tx_busy(tx_busy),
    .state(state), .drop_cnt(drop_cnt), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  // Phase-level model: 0 idle, 1 load, 2 compute, 3 send
  int m_ph = 0, m_silent = 0, m_quiet = 0, m_drops = 0;
  bit m_seen = 0, m_conf = 0, m_mxs = 0, m_pss = 0, m_fl = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_silent = 0; m_quiet = 0; m_drops = 0;
      m_seen = 0; m_conf = 0; m_mxs = 0; m_pss = 0; m_fl = 0;
    end else begin
      m_mxs = 0; m_pss = 0; m_fl = 0;
      if (rx_valid && m_ph >= 2) m_drops++;
      if ((ld_wr_en && m_ph != 1) || (mx_wr_en && m_ph != 2)) m_conf = 1;
      if (m_ph == 0) begin
        if (rx_valid) begin m_ph = 1; m_silent = 0; end
      end else if (m_ph == 1) begin
        if (ld_done) begin m_ph = 2; m_mxs = 1; end
        else if (rx_error || m_silent == LT - 1) begin m_ph = 0; m_fl = 1; end
        else m_silent = rx_valid ? 0 : m_silent + 1;
      end else if (m_ph == 2) begin
        if (mx_stop) begin m_ph = 3; m_pss = 1; m_seen = 0; m_quiet = 0; end
      end else begin
        if (tx_busy) begin m_seen = 1; m_quiet = 0; end
        else if (m_seen) begin
          m_quiet++;
          if (m_quiet == SQ) begin m_ph = 0; m_seen = 0; m_quiet = 0; end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic        ee;
    logic [7:0]  ea;
    logic [31:0] ed;
    ee = 1'b0; ea = 8'd0; ed = 32'd0;
    if (m_ph == 1) begin ee = ld_wr_en; ea = ld_wr_addr; ed = ld_wr_data; end
    else if (m_ph == 2) begin ee = mx_wr_en; ea = mx_wr_addr; ed = mx_wr_data; end
    check("state", state, m_ph);
    check("ld_rx_valid", ld_rx_valid, rx_valid && m_ph <= 1);
    check("ld_rx_byte", ld_rx_byte, rx_byte);
    check("ld_flush", ld_flush, m_fl);
    check("mx_start", mx_start, m_mxs);
    check("ps_start", ps_start, m_pss);
    check("drop_cnt", drop_cnt, (m_drops > 255) ? 255 : m_drops);
    check("wr_conflict", wr_conflict, m_conf);
    check("br_wr_en", br_wr_en, ee);
    check("br_wr_addr", br_wr_addr, ea);
    check("br_wr_data", br_wr_data, ed);
  endtask

  // inputs are set at a negedge; compare before the posedge, return at the next negedge
  task automatic tick();
    #2;
    compare_all();
    @(negedge clk);
  endtask

  task automatic clr();
    rx_valid = 0; rx_byte = 0; rx_error = 0; ld_done = 0;
    ld_wr_en = 0; ld_wr_addr = 0; ld_wr_data = 0;
    mx_stop = 0; mx_wr_en = 0; mx_wr_addr = 0; mx_wr_data = 0; tx_busy = 0;
  endtask

  task automatic byte_in();
    rx_valid = 1; rx_byte = 8'($urandom);
    tick();
    clr();
  endtask

  initial begin
    int j;
    clr();
    rst = 1;
    @(negedge clk);
    tick(); tick();
    check("rst_state", state, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_conf", wr_conflict, 0);
    check("rst_pulses", {mx_start, ps_start, ld_flush}, 0);
    rst = 0;

    // full job with loader writes
    for (int i = 0; i < 12; i++) begin
      rx_valid = 1; rx_byte = 8'($urandom);
      ld_wr_en = (i > 0); ld_wr_addr = 8'($urandom); ld_wr_data = $urandom;
      if (i == 0) begin #1; check("fwd_first", ld_rx_valid, 1); end
      if (i == 5) begin
        ld_wr_addr = 8'h12; ld_wr_data = 32'hDEADBEEF;
        #1;
        check("br_en_load", br_wr_en, 1);
        check("br_addr_load", br_wr_addr, 8'h12);
        check("br_data_load", br_wr_data, 32'hDEADBEEF);
      end
      tick(); clr();
      if (i == 0) check("load_state", state, 1);
      repeat ($urandom_range(0, 3)) tick();
    end
    rx_valid = 1; ld_done = 1;
    #1; check("fwd_with_done", ld_rx_valid, 1);
    tick(); clr();
    check("compute_state", state, 2);
    check("mx_start_hi", mx_start, 1);
    tick();
    check("mx_start_lo", mx_start, 0);

    for (int i = 0; i < 5; i++) begin
      rx_valid = 1;
      #1; check("drop_gate", ld_rx_valid, 0);
      tick(); clr();
      mx_wr_en = 1; mx_wr_addr = 8'($urandom); mx_wr_data = $urandom;
      tick(); clr();
    end
    check("drop5", drop_cnt, 5);
    check("conf_clean", wr_conflict, 0);
    ld_wr_en = 1; ld_wr_addr = 8'h12; ld_wr_data = 32'hDEADBEEF;
    #1; check("br_en_blocked", br_wr_en, 0);
    tick(); clr();
    check("conf_set", wr_conflict, 1);

    mx_stop = 1; tick(); clr();
    check("send_state", state, 3);
    check("ps_start_hi", ps_start, 1);
    tick();
    check("ps_start_lo", ps_start, 0);
    tx_busy = 1; repeat (20) tick();
    tx_busy = 0; repeat (SQ - 1) tick();
    check("send_hold", state, 3);
    tick();
    check("send_done", state, 0);

    mx_stop = 1; tick(); clr();
    check("ps_idle", ps_start, 0);
    check("idle_stays", state, 0);

    // load timeout
    byte_in(); byte_in(); byte_in();
    j = 0;
    while (j < LT + 100) begin
      tick(); j++;
      if (ld_flush) break;
    end
    check("timeout_cycle", j, LT);
    check("timeout_state", state, 0);
    tick();
    check("flush_one_cycle", ld_flush, 0);

    // rx_error abort
    byte_in(); byte_in();
    rx_error = 1; tick(); clr();
    check("err_flush", ld_flush, 1);
    check("err_state", state, 0);
    tick();
    check("err_flush_lo", ld_flush, 0);

    // ld_done beats rx_error, then drop saturation
    byte_in();
    ld_done = 1; rx_error = 1; tick(); clr();
    check("done_wins_state", state, 2);
    check("done_wins_noflush", ld_flush, 0);
    for (int i = 0; i < 300; i++) begin rx_valid = 1; tick(); end
    clr();
    check("drop_sat", drop_cnt, 255);
    mx_stop = 1; tick(); clr();
    tx_busy = 1; repeat (3) tick();
    tx_busy = 0; repeat (SQ) tick();
    check("job2_done", state, 0);

    // async reset mid-compute
    byte_in();
    ld_done = 1; tick(); clr();
    repeat (3) tick();
    #2; rst = 1; #1;
    check("arst_state", state, 0);
    check("arst_pulses", {mx_start, ps_start, ld_flush}, 0);
    check("arst_drop", drop_cnt, 0);
    check("arst_conf", wr_conflict, 0);
    check("arst_br_en", br_wr_en, 0);
    check("arst_fwd", ld_rx_valid, 0);
    @(negedge clk);
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1; rx_byte = 8'($urandom);
      ld_wr_en = (i > 0); ld_wr_addr = 8'($urandom); ld_wr_data = $urandom;
      tick(); clr();
    end
    ld_done = 1; tick(); clr();
    check("rejob_compute", state, 2);
    check("rejob_mx_start", mx_start, 1);
    mx_stop = 1; tick(); clr();
    check("rejob_send", state, 3);
    tx_busy = 1; repeat (5) tick();
    tx_busy = 0; repeat (SQ) tick();
    check("rejob_idle", state, 0);
    check("rejob_noconf", wr_conflict, 0);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_byte  = 8'($urandom);
      rx_error = ($urandom_range(0, 99) == 0);
      ld_done  = ($urandom_range(0, 29) == 0);
      mx_stop  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) tx_busy = ~tx_busy;
      ld_wr_en = ($urandom_range(0, 3) == 0) && (m_ph == 1 || $urandom_range(0, 199) == 0);
      mx_wr_en = ($urandom_range(0, 3) == 0) && (m_ph == 2 || $urandom_range(0, 199) == 0);
      ld_wr_addr = 8'($urandom); ld_wr_data = $urandom;
      mx_wr_addr = 8'($urandom); mx_wr_data = $urandom;
      tick();
    end
    clr();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
